uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 4, giving the number of transmit FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic rising-edge triggered.
REQ-003 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 The block SHALL have port sample_tick, input, 1, one-clk strobe at 16x baud rate.
REQ-005 The block SHALL have port tx_data, input, 8, byte to transmit.
REQ-006 The block SHALL have port tx_valid, input, 1, write request for tx_data.
REQ-007 The block SHALL have port tx_ready, output, 1, FIFO can accept a byte (count < FIFO_DEPTH).
REQ-008 The block SHALL have port parity_en, input, 1, append a parity bit.
REQ-009 The block SHALL have port parity_type, input, 1, 0 = even, 1 = odd.
REQ-010 The block SHALL have port txd, output, 1, serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1, high while the FSM is outside IDLE.
REQ-012 The block SHALL have port tx_done, output, 1, one-clk pulse at frame completion.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of stored bytes.

Function
REQ-014 The block SHALL write tx_data into the FIFO on any clk edge where tx_valid && tx_ready, independent of sample_tick.
REQ-015 tx_ready SHALL be derived from the registered fifo_count; a push attempted while full SHALL be dropped with no state change.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions SHALL occur only on clk edges with sample_tick=1.
REQ-017 In IDLE on sample_tick with fifo_count>0, the block SHALL pop the head byte into a shift register, latch parity_en/parity_type, drive txd=0, clear the tick counter, and enter START.
REQ-018 Each bit (START, each DATA bit, PARITY, STOP) SHALL last exactly 16 sample_ticks; a 4-bit counter SHALL advance per tick, and at count 15 the block SHALL advance to the next bit and reset the counter.
REQ-019 DATA SHALL send 8 bits LSB first, then go to PARITY if latched parity_en=1, else to STOP.
REQ-020 The parity bit SHALL be the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-021 STOP SHALL drive txd=1; at its 16th tick the block SHALL pulse tx_done for one clk and return to IDLE.
REQ-022 A FIFO that is non-empty at the next sample_tick SHALL start the next frame back-to-back with no extra idle bits.
REQ-023 A push and a pop in the same clk SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-024 A push into an empty FIFO SHALL NOT bypass the FIFO; transmission SHALL start on the first sample_tick after the push.
REQ-025 Changes to parity_en/parity_type mid-frame SHALL affect only subsequent frames.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 With sample_tick held low, the FSM and txd SHALL hold their state, and FIFO pushes SHALL still be accepted.

Reset
REQ-028 Asserting reset SHALL immediately set txd=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1, state=IDLE, and clear the counters and pointers.
REQ-029 Reset mid-frame SHALL abort the frame, discard all FIFO contents, and return txd high with no glitch low.

Verification
REQ-030 Push 0xA5 with parity_en=0: txd SHALL be 0,1,0,1,0,0,1,0,1,1, each value held 16 ticks; tx_done SHALL pulse once; 160 ticks total.
REQ-031 Push 0xA5 with even parity, then 0x07 with odd parity: the parity bit SHALL be 0 for 0xA5 and 0 for 0x07; frames SHALL be 176 ticks each and back-to-back.
REQ-032 Push 5 bytes in consecutive clks with FIFO_DEPTH=4 and sample_tick low: the first 4 SHALL be accepted, tx_ready SHALL be 0, the 5th SHALL be dropped, fifo_count=4.
REQ-033 Full FIFO with a pop and a push in the same clk: fifo_count SHALL stay 4 and byte order SHALL be preserved across pointer wrap.
REQ-034 Assert reset during DATA bit 3: txd SHALL be 1 and fifo_count SHALL be 0 immediately; a new push SHALL transmit a correct frame.
REQ-035 Toggle parity_type during DATA: the current frame's parity SHALL use the latched type.

Source files
------------

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx -- 8-bit UART transmitter with a small transmit FIFO.
//
// Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit,
// 1 stop bit (1). Each bit lasts 16 sample_tick strobes (16x oversampled
// baud). Parity enable/type are latched when a frame starts, so changing
// them mid-frame only affects later frames.
//
// Handshake: a byte is written when tx_valid && tx_ready are both high on a
// rising clk edge. tx_ready depends only on the registered fifo_count, never
// on tx_valid. A write offered while tx_ready is low is dropped, and the
// FIFO state does not change.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   sample_tick  one-clk strobe at 16x baud
//   tx_data      byte to transmit
//   tx_valid     write request for tx_data
//   tx_ready     FIFO has room (fifo_count < FIFO_DEPTH)
//   parity_en    append a parity bit to frames that start from now on
//   parity_type  0 = even, 1 = odd
//   txd          serial line, idle high
//   tx_busy      FSM is outside IDLE
//   tx_done      one-clk pulse when a stop bit completes
//   fifo_count   number of stored bytes
//   state_dbg    current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          parity_en,
    input  logic                          parity_type,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    head;
    logic          push;
    logic          load;

    // Frame-sequencer state
    logic [2:0] state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_en_q;
    logic       par_bit_q;
    logic       tick_last;

    assign tx_ready  = (fifo_count < DEPTH_C);
    assign push      = tx_valid && tx_ready;
    assign head      = mem[rd_ptr];
    assign tick_last = (tick_cnt == 4'd15);

    // A new frame is loaded from IDLE, or straight out of the last stop-bit
    // tick so consecutive frames run back-to-back without idle bits.
    assign load = sample_tick && (fifo_count != '0) &&
                  ((state == S_IDLE) || ((state == S_STOP) && tick_last));

    // Pointers are AW bits wide, so they wrap modulo the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: reset clears the pointers and count, which
    // makes every entry unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. Everything but tx_done advances only on ticks.
    // txd is a register so reset drives it high without a low glitch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            txd       <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= sample_tick && (state == S_STOP) && tick_last;
            if (load) begin
                shreg     <= head;
                par_en_q  <= parity_en;
                // Even parity is the plain XOR; odd inverts it.
                par_bit_q <= (^head) ^ parity_type;
                txd       <= 1'b0;
                tick_cnt  <= '0;
                state     <= S_START;
            end else if (sample_tick) begin
                case (state)
                    S_IDLE: begin
                        tick_cnt <= '0;
                    end
                    S_START: begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            txd      <= shreg[0];
                            state    <= S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                if (par_en_q) begin
                                    txd   <= par_bit_q;
                                    state <= S_PARITY;
                                end else begin
                                    txd   <= 1'b1;
                                    state <= S_STOP;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                txd     <= shreg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            txd      <= 1'b1;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    S_STOP: begin
                        // The back-to-back case is taken by the load branch.
                        if (tick_last) begin
                            tick_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    default: begin
                        tick_cnt <= '0;
                        txd      <= 1'b1;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_busy   = (state != S_IDLE);
    assign state_dbg = state;

endmodule
